// File: rtl/st_4b_pkg.sv
// Shared definitions for the st_4b serial transmitter: FSM state codes,
// data/counter widths and the small bit-level helpers used by the FSM.
package st_4b_pkg;

  localparam int DATA_BITS = 4;
  localparam int CNT_W     = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Even parity over the captured nibble (1 when the count of ones is odd).
  function automatic logic even_par(input logic [DATA_BITS-1:0] v);
    return ^v;
  endfunction

  // Serial bit number idx of nibble v, taken from the top or the bottom end.
  function automatic logic pick_bit(input logic [DATA_BITS-1:0] v,
                                    input logic [1:0] idx,
                                    input logic msb_first);
    logic b;
    if (msb_first) begin
      b = v[2'd3 - idx];
    end else begin
      b = v[idx];
    end
    return b;
  endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period timer: counts clock cycles while a frame runs and flags the
// last cycle of every bit period. Held at zero whenever run is low so each
// frame starts on a clean period boundary.
module ser_bit_timer
  import st_4b_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter: 0..CLKS_PER_BIT-1, wraps on each bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!run || tick) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick = run && (cnt_r == LAST_CNT);

endmodule

// File: rtl/st_4b_ser.sv
// Serial transmitter for the st_4b nibble: accepts one nibble over a
// valid/ready handshake and sends start, 4 data bits, optional even parity
// and stop on a single idle-high line. All ports are driven from flops.
module st_4b_ser
  import st_4b_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [3:0] d,
  output logic       d_ready,
  output logic       ser_out,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] BIT_LAST = 2'(DATA_BITS - 1);
  localparam logic       MSB_SEL  = (MSB_FIRST != 0);

  logic [2:0] state_r;
  logic [3:0] shreg_r;
  logic       par_r;
  logic [1:0] bitcnt_r;
  logic       run_s;
  logic       tick_s;

  // The timer only runs while a frame is on the wire.
  assign run_s = (state_r != ST_IDLE);

  ser_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .run  (run_s),
    .tick (tick_s)
  );

  // Frame FSM; the nibble is latched at acceptance and never touched mid-frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      shreg_r  <= 4'd0;
      par_r    <= 1'b0;
      bitcnt_r <= 2'd0;
      ser_out  <= 1'b1;
      d_ready  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (d_valid) begin
            shreg_r <= d;
            par_r   <= even_par(d);
            state_r <= ST_START;
            ser_out <= 1'b0;
            busy    <= 1'b1;
            d_ready <= 1'b0;
          end
        end
        ST_START: begin
          if (tick_s) begin
            state_r  <= ST_DATA;
            bitcnt_r <= 2'd0;
            ser_out  <= pick_bit(shreg_r, 2'd0, MSB_SEL);
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (bitcnt_r == BIT_LAST) begin
              bitcnt_r <= 2'd0;
              if (PARITY_EN != 0) begin
                state_r <= ST_PARITY;
                ser_out <= par_r;
              end else begin
                state_r <= ST_STOP;
                ser_out <= 1'b1;
              end
            end else begin
              bitcnt_r <= bitcnt_r + 2'd1;
              ser_out  <= pick_bit(shreg_r, bitcnt_r + 2'd1, MSB_SEL);
            end
          end
        end
        ST_PARITY: begin
          if (tick_s) begin
            state_r <= ST_STOP;
            ser_out <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            state_r <= ST_IDLE;
            ser_out <= 1'b1;
            done    <= 1'b1;
            d_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          bitcnt_r <= 2'd0;
          ser_out  <= 1'b1;
          d_ready  <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st_4b_ser.sv
// Bench for st_4b_ser: three configurations side by side (defaults, LSB-first,
// one cycle per bit without parity). A per-cycle scoreboard predicts
// {ser_out, busy, done, d_ready} from accepted nibbles; a vector table and a
// few hand sequences check bit values and the multi-cycle corner cases.
module tb_st_4b_ser;

  typedef logic [2:0] ent_t;  // {ser_out, busy, done}
  typedef struct {
    int         k;
    logic [3:0] v;
    logic [6:0] bits;
    int         n;
  } vec_t;

  localparam int   CPB [3] = '{4, 4, 1};
  localparam int   PEN [3] = '{1, 1, 0};
  localparam int   MSB [3] = '{1, 0, 1};
  localparam ent_t IDLE_E  = 3'b100;
  localparam ent_t DONE_E  = 3'b101;

  logic       clk;
  logic       reset;
  logic       dv   [3];
  logic [3:0] dd   [3];
  logic       rdy  [3];
  logic       sout [3];
  logic       bsy  [3];
  logic       dn   [3];

  ent_t sb0[$];
  ent_t sb1[$];
  ent_t sb2[$];
  bit   exp_rdy [3];

  int checks = 0;
  int errors = 0;

  st_4b_ser #(.CLKS_PER_BIT(4), .PARITY_EN(1), .MSB_FIRST(1)) dut0 (
    .clk(clk), .reset(reset), .d_valid(dv[0]), .d(dd[0]),
    .d_ready(rdy[0]), .ser_out(sout[0]), .busy(bsy[0]), .done(dn[0]));
  st_4b_ser #(.CLKS_PER_BIT(4), .PARITY_EN(1), .MSB_FIRST(0)) dut1 (
    .clk(clk), .reset(reset), .d_valid(dv[1]), .d(dd[1]),
    .d_ready(rdy[1]), .ser_out(sout[1]), .busy(bsy[1]), .done(dn[1]));
  st_4b_ser #(.CLKS_PER_BIT(1), .PARITY_EN(0), .MSB_FIRST(1)) dut2 (
    .clk(clk), .reset(reset), .d_valid(dv[2]), .d(dd[2]),
    .d_ready(rdy[2]), .ser_out(sout[2]), .busy(bsy[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic q_push(input int k, input ent_t e);
    case (k)
      0: sb0.push_back(e);
      1: sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic q_clear(input int k);
    case (k)
      0: sb0.delete();
      1: sb1.delete();
      default: sb2.delete();
    endcase
  endtask

  task automatic q_pop(input int k, output ent_t e, output bit got);
    got = 1'b0;
    e   = IDLE_E;
    case (k)
      0: if (sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
      1: if (sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
      default: if (sb2.size() > 0) begin e = sb2.pop_front(); got = 1'b1; end
    endcase
  endtask

  // Expected per-cycle line state for one accepted nibble, then the done cycle.
  task automatic push_frame(input int k, input logic [3:0] v);
    logic fb [7];
    int   n;
    fb[0] = 1'b0;
    for (int i = 0; i < 4; i++) fb[1+i] = (MSB[k] != 0) ? v[3-i] : v[i];
    n = 5;
    if (PEN[k] != 0) begin fb[n] = ^v; n++; end
    fb[n] = 1'b1;
    n++;
    for (int i = 0; i < n; i++)
      for (int c = 0; c < CPB[k]; c++) q_push(k, {fb[i], 1'b1, 1'b0});
    q_push(k, DONE_E);
  endtask

  task automatic mon_check(input int k);
    ent_t e;
    bit   got;
    e = IDLE_E;
    if (!reset) q_clear(k);
    else q_pop(k, e, got);
    exp_rdy[k] = ~e[1];
    cmp($sformatf("cycle_dut%0d", k), 8'({sout[k], bsy[k], dn[k], rdy[k]}),
        8'({e, ~e[1]}));
  endtask

  // Scoreboard: record acceptances at the edge, compare outputs just after it.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (reset && dv[k] && exp_rdy[k]) push_frame(k, dd[k]);
    #1;
    for (int k = 0; k < 3; k++) mon_check(k);
  end

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (bsy[k] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    cmp($sformatf("idle_timeout_dut%0d", k), 8'(n < 200), 8'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input int k, input logic [3:0] v, input logic [6:0] bits, input int n);
    @(negedge clk);
    dv[k] = 1'b1;
    dd[k] = v;
    @(negedge clk);
    dv[k] = 1'b0;
    dd[k] = ~v;
    for (int i = 0; i < n; i++) begin
      cmp($sformatf("vec_dut%0d_d%b_bit%0d", k, v, i), 8'(sout[k]), 8'(bits[n-1-i]));
      repeat (CPB[k]) @(negedge clk);
    end
    wait_idle(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    int   n;
    vt[0] = '{0, 4'b1010, 7'b0101001, 7};
    vt[1] = '{0, 4'b1011, 7'b0101111, 7};
    vt[2] = '{1, 4'b1011, 7'b0110111, 7};
    vt[3] = '{1, 4'b1010, 7'b0010101, 7};
    vt[4] = '{2, 4'b0110, 7'b0001101, 6};
    vt[5] = '{2, 4'b1001, 7'b0010011, 6};

    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin dv[k] = 1'b0; dd[k] = 4'd0; end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++)
      cmp($sformatf("reset_state_dut%0d", k), 8'({sout[k], bsy[k], dn[k], rdy[k]}), 8'b1001);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vt[i].k, vt[i].v, vt[i].bits, vt[i].n);

    // Back-to-back: valid held high, nibble changed while the first frame runs.
    @(negedge clk);
    dv[0] = 1'b1;
    dd[0] = 4'b1100;
    @(negedge clk);
    dd[0] = 4'b0011;
    n = 0;
    while (dn[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmp("b2b_done_seen", 8'(n < 100), 8'd1);
    cmp("b2b_gap_high", 8'({sout[0], bsy[0]}), 8'b10);
    @(negedge clk);
    dv[0] = 1'b0;
    cmp("b2b_second_start", 8'({sout[0], bsy[0], rdy[0]}), 8'b010);
    repeat (8) begin
      @(negedge clk);
      dd[0] = 4'($urandom_range(0, 15));
    end
    wait_idle(0);

    // Reset during DATA aborts the frame at once; valid during reset is ignored.
    @(negedge clk);
    dv[0] = 1'b1;
    dd[0] = 4'b1111;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (5) @(negedge clk);
    cmp("pre_reset_data_bit", 8'({sout[0], bsy[0]}), 8'b11);
    reset = 1'b0;
    dv[1] = 1'b1;
    dd[1] = 4'b0101;
    #1;
    cmp("reset_async_abort", 8'({sout[0], bsy[0], dn[0], rdy[0]}), 8'b1001);
    repeat (2) @(negedge clk);
    dv[1] = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmp("post_reset_idle_dut1", 8'({sout[1], bsy[1]}), 8'b10);
    run_vec(0, 4'b0001, 7'b0000111, 7);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/st_4b_ser.md
Name: st_4b_ser

Overview:
- Downstream consumer of the 4-bit storage register st_4b. Takes its registered nibble over a valid/ready handshake and transmits it as a UART-style serial frame on one wire.
- Frame order: start bit (0), 4 data bits, optional even-parity bit, stop bit (1).
- Each bit is held for a programmable number of clock cycles.

Parameters:
- CLKS_PER_BIT, 4: clock cycles each serial bit is held; legal range 1..255.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
- MSB_FIRST, 1: 1 sends d[3] first; 0 sends d[0] first.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- d_valid  input  1  upstream nibble available.
- d  input  4  nibble from st_4b q.
- d_ready  output  1  block can accept a nibble this cycle.
- ser_out  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- done  output  1  single-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ser_out=1, d_ready=1, busy=0, done=0, shift register=0, bit counter=0, cycle counter=0.
  - Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - d_ready=1, ser_out=1, busy=0.
  - On a rising edge with d_valid=1: capture d into the shift register, compute parity = ^d, go to START.
  - At that same edge: ser_out=0, busy=1, d_ready=0.
- START: hold ser_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Present 4 bits in order per MSB_FIRST, each for CLKS_PER_BIT cycles.
  - The bit counter counts 0..3. After bit 3, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: ser_out = XOR of the 4 captured bits (even parity), held CLKS_PER_BIT cycles, then go to STOP.
- STOP: ser_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - At that edge: done=1 for exactly one cycle (the first IDLE cycle), d_ready=1, busy=0.
- Frame length: (6 + PARITY_EN) × CLKS_PER_BIT cycles from the capture edge to the IDLE edge.
- Back-to-back frames:
  - A nibble offered during the first IDLE cycle (the done cycle) is accepted.
  - Minimum inter-frame gap is 1 idle-high cycle.
- Changes on d or d_valid while busy=1 are ignored. The captured nibble is immutable until the next acceptance.
- CLKS_PER_BIT=1: one cycle per bit, no idle cycles inside the frame.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit transition. It is 8 bits wide.
- d_valid high while reset is asserted: ignored. The first capture can occur on the first rising edge after reset releases.

Decomposition:
- Shared package st_4b_pkg:
  - state encoding for IDLE/START/DATA/PARITY/STOP (3 bits, one localparam per state);
  - localparam DATA_BITS = 4;
  - localparam CNT_W = 8.
- One sub-module, ser_bit_timer:
  - ports: clk, reset, run, tick;
  - parameter CLKS_PER_BIT;
  - tick pulses on the last cycle of each bit period;
  - the counter restarts whenever run is low.
- The FSM, shift register and parity logic stay in st_4b_ser.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, release, no d_valid for 10 cycles -> ser_out=1, d_ready=1, busy=0, done=0 throughout.
- Basic frame (defaults): d=4'b1010, d_valid for 1 cycle -> ser_out sequence 0,1,0,1,0,0,1, each held 4 cycles (28 cycles total); done pulses once; busy high for exactly 28 cycles.
- Odd parity data: d=4'b1011 -> data bits 1,0,1,1, parity bit 1; with MSB_FIRST=0 the data bits appear as 1,1,0,1.
- Back-to-back: d_valid held high with d=4'b1100, then d=4'b0011 -> second frame's start bit begins 1 cycle after the first done; parity bits are 0 and 0; d changes mid-frame do not corrupt the serial output.
- Reset mid-frame: assert reset=0 during the DATA state of d=4'b1111 -> ser_out=1 and busy=0 immediately (asynchronous), no done pulse; after release, a new frame with d=4'b0001 is correct.
- CLKS_PER_BIT=1, PARITY_EN=0: d=4'b0110 -> ser_out 0,0,1,1,0,1 on consecutive cycles; done 6 cycles after capture.
